// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode encodings, FSM state type and counter sizing for the ALU sequencer.
package alu_seq_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/alu_op_sequencer_iter_step.sv
// One combinational iteration: a shift-add multiply step or a restoring divide step.
module alu_iter_step
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic [1:0]         op_i,
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [2*WIDTH-1:0] mcand_i,
   input  logic               mplier_bit_i,
   input  logic [WIDTH-1:0]   divisor_i,
   output logic [2*WIDTH-1:0] acc_o
);

   logic [2*WIDTH:0]   shifted_s;
   logic [WIDTH:0]     rem_wide_s;
   logic [WIDTH-1:0]   rem_diff_s;
   logic               rem_ge_s;

   // Divide: acc holds {remainder, dividend/quotient}; shift left, try to subtract the divisor.
   always_comb begin
      shifted_s  = {acc_i, 1'b0};
      rem_wide_s = shifted_s[2*WIDTH:WIDTH];
      rem_ge_s   = (rem_wide_s >= {1'b0, divisor_i});
      // A successful trial difference is below the divisor, so WIDTH bits suffice.
      rem_diff_s = rem_wide_s[WIDTH-1:0] - divisor_i;
      acc_o      = acc_i;
      if (op_i == OP_DIV) begin
         if (rem_ge_s) begin
            acc_o = {rem_diff_s, shifted_s[WIDTH-1:1], 1'b1};
         end else begin
            acc_o = shifted_s[2*WIDTH-1:0];
         end
      end else begin
         if (mplier_bit_i) begin
            acc_o = acc_i + mcand_i;
         end else begin
            acc_o = acc_i;
         end
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Request/response sequencer for add/sub (single cycle) and iterative mul/div.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_op,
   input  logic [WIDTH-1:0]   req_a,
   input  logic [WIDTH-1:0]   req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [2*WIDTH-1:0] rsp_result,
   output logic               rsp_err,
   output logic               busy
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);
   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

   seq_state_t         state_q;
   logic [CW-1:0]      cnt_q;
   logic [1:0]         op_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [2*WIDTH-1:0] result_q;
   logic               err_q;

   alu_iter_step #(.WIDTH(WIDTH)) u_step (
      .op_i         (op_q),
      .acc_i        (acc_q),
      .mcand_i      (mcand_q),
      .mplier_bit_i (b_q[0]),
      .divisor_i    (b_q),
      .acc_o        (acc_d)
   );

   // Sequencer FSM with counter, operand, accumulator and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= 2'b00;
         mcand_q  <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op;
                  mcand_q <= {ZERO_W, req_a};
                  b_q     <= req_b;
                  cnt_q   <= CNT_LOAD;
                  acc_q   <= (req_op == OP_DIV) ? {ZERO_W, req_a} : '0;
                  case (req_op)
                     OP_ADD: begin
                        result_q <= {ZERO_W, req_a} + {ZERO_W, req_b};
                        err_q    <= 1'b0;
                        state_q  <= DONE;
                     end
                     OP_SUB: begin
                        result_q <= {ZERO_W, req_a} - {ZERO_W, req_b};
                        err_q    <= 1'b0;
                        state_q  <= DONE;
                     end
                     OP_MUL: begin
                        state_q <= EXEC;
                     end
                     OP_DIV: begin
                        if (req_b == ZERO_W) begin
                           result_q <= '1;
                           err_q    <= 1'b1;
                           state_q  <= DONE;
                        end else begin
                           state_q <= EXEC;
                        end
                     end
                     default: state_q <= IDLE;
                  endcase
               end
            end
            EXEC: begin
               acc_q   <= acc_d;
               mcand_q <= mcand_q << 1;
               b_q     <= (op_q == OP_MUL) ? (b_q >> 1) : b_q;
               cnt_q   <= cnt_q - CNT_LAST;
               if (cnt_q == CNT_LAST) begin
                  result_q <= acc_d;
                  err_q    <= 1'b0;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign rsp_valid  = (state_q == DONE);
   assign busy       = (state_q == EXEC) || (state_q == DONE);
   assign rsp_result = result_q;
   assign rsp_err    = err_q;

endmodule
